// File: rtl/if_id_stage_pkg.sv
// Shared widths, default constants and the IF/ID register layout used by the fetch stage.
package if_id_stage_pkg;

  localparam int unsigned WordW = 32;

  // sll $0,$0,0
  localparam logic [WordW-1:0] NopInstrDefault = 32'h0000_0000;
  localparam logic [WordW-1:0] ResetPcDefault  = 32'h0000_0000;

  typedef struct packed {
    logic [WordW-1:0] pc;
    logic [WordW-1:0] pc_plus4;
    logic [WordW-1:0] instr;
    logic             valid;
  } ifid_t;

  // Which of the four mutually exclusive update rules applies this cycle.
  typedef enum logic [1:0] {
    SelStall,
    SelRedirect,
    SelWait,
    SelFetch
  } if_sel_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface if_id_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
module if_id_stage_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage of the 5-stage MIPS core: owns the PC, drives imem and holds the IF/ID register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPcDefault,
  parameter logic [31:0] NOP_INSTR = NopInstrDefault,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [WordW-1:0]     redirect_target_i,
  if_id_stage_if.master        imem_io,
  output logic [WordW-1:0]     pc_id_o,
  output logic [WordW-1:0]     pc_plus4_id_o,
  output logic [WordW-1:0]     instr_id_o,
  output logic                 valid_id_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  logic [WordW-1:0] pc_q, pc_d;
  logic [WordW-1:0] pc_plus4;
  ifid_t            ifid_q, ifid_d;
  if_sel_e          sel;
  logic             stall_inc;
  logic             bubble_inc;

  // Redirect targets are word-aligned; the low bits are dropped by design.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target_i[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (stall_i) begin
      sel = SelStall;
    end else if (redirect_i) begin
      sel = SelRedirect;
    end else if (!imem_io.imem_ready) begin
      sel = SelWait;
    end else begin
      sel = SelFetch;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    unique case (sel)
      SelStall: ;
      SelRedirect: begin
        pc_d         = {redirect_target_i[31:2], 2'b00};
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
      SelWait: begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
      SelFetch: begin
        pc_d            = pc_plus4;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.instr    = imem_io.imem_rdata;
        ifid_d.valid    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.valid    <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign stall_inc  = (sel == SelStall);
  assign bubble_inc = (sel == SelRedirect) || (sel == SelWait);

  if_id_stage_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt_o)
  );

  if_id_stage_sat_counter #(
    .Width (CNT_W)
  ) u_bubble_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (bubble_inc),
    .cnt_o  (bubble_cnt_o)
  );

  assign imem_io.imem_addr = pc_q;
  assign pc_id_o           = ifid_q.pc;
  assign pc_plus4_id_o     = ifid_q.pc_plus4;
  assign instr_id_o        = ifid_q.instr;
  assign valid_id_o        = ifid_q.valid;

endmodule
